dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's load/store interface.
- Accepts one request at a time over a valid/ready handshake and applies a configurable number of wait states.
- Performs byte, half or word writes into an internal word array, or returns lane-aligned, zero-extended read data.
- Sits behind the core's memory-control/memory-select logic. Sign extension stays downstream in the load-select path.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array. Valid word index range is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 1, wait states between accept and response. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  32  load data, zero-extended, right-justified; 0 for stores and errors
- rsp_err  output  1  request was rejected: misaligned, illegal size or out of range
- busy  output  1  a request has been accepted and its response not yet consumed

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset state: FSM = IDLE, wait counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, busy = 0.
- req_ready is 1 exactly in IDLE, so it reads 1 immediately after reset release.
- Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req_valid && req_ready, latch we/size/addr/wdata and compute the error flag.
  - Next state is WAIT with counter = WAIT_CYCLES-1, or RESP if WAIT_CYCLES == 0.
- WAIT: decrement the counter each cycle. At 0, go to RESP.
- Commit on the RESP-entry edge:
  - Stores without error write the array.
  - Loads sample the array into rsp_rdata.
  - rsp_valid and rsp_err register on the same edge.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready is 1.
  - On that edge, rsp_valid and rsp_err clear and the FSM returns to IDLE.
  - The next request can be accepted no earlier than the cycle after the handshake; there is no back-to-back overlap.
  - rsp_ready asserted outside RESP is ignored.
- Addressing: word index = addr[31:2], lane = addr[1:0].
- Error conditions (any one of these sets rsp_err):
  - size = 11
  - size = 01 with addr[0] = 1
  - size = 10 with addr[1:0] ≠ 00
  - word index ≥ DEPTH_WORDS
- On error: no array write, rsp_rdata = 0, rsp_err = 1 with rsp_valid. Latency is the same as a normal access.
- Store merge:
  - Byte: wdata[7:0] into byte lane addr[1:0].
  - Half: wdata[15:0] into half lane addr[1].
  - Word: full replace.
  - Untouched lanes keep their old values.
- Load extract:
  - Byte: selected byte shifted to bits [7:0], upper bits 0.
  - Half: selected half shifted to [15:0], upper bits 0.
  - Word: as stored.
- Request inputs are ignored outside IDLE; the core must hold req_valid until accept.
- Reset mid-operation: the FSM returns to IDLE immediately. A store still in WAIT is discarded. A store already committed (FSM in RESP) remains in the array, and its response is dropped.

Test Plan:
- WAIT_CYCLES=1: word store 0xDEADBEEF @0x10, then word load @0x10 → each rsp_valid rises 2 cycles after accept; load rdata = 0xDEADBEEF, err = 0.
- Byte store 0x5A @0x11 onto word 0x00000000, then word load @0x10 → 0x00005A00. Half load @0x12 → 0x00000000.
- Byte load @0x13 of word 0x80FF1234 → rdata = 0x00000080 (zero-extended); half load @0x12 → 0x000080FF.
- Misaligned word store @0x12 with wdata 0xFFFFFFFF → rsp_err = 1, rdata = 0, word @0x10 unchanged.
- Out-of-range: word load at addr = DEPTH_WORDS*4 → rsp_err = 1.
- size = 11 → rsp_err = 1.
- Back-pressure and reset:
  - Hold rsp_ready = 0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. req_ready returns to 1 the cycle after rsp_ready goes high.
  - Assert rst_n low during WAIT of a store (WAIT_CYCLES=3) → outputs clear asynchronously; a later load shows the old data.
  - Also run with WAIT_CYCLES=0 → latency is 1 cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core load/store port.
// One request in flight at a time, WAIT_CYCLES wait states, then a held
// response. Stores merge byte/half/word lanes into a word array; loads
// return zero-extended, right-justified data.
//
// Handshake semantics (both channels): a transfer happens on the rising
// clk edge where valid && ready are both 1. The request side only accepts
// in IDLE (req_ready is 1 exactly there). The response side holds
// rsp_valid/rsp_rdata/rsp_err stable until the edge where rsp_ready is 1.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // FSM state is kept as a named internal signal so checkers can bind to it
    state_t      state;
    logic [3:0]  cnt;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    // Commit-side view of the request: live inputs on a zero-wait accept,
    // otherwise the copy latched at accept time.
    logic             c_we;
    logic [1:0]       c_size;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic             c_err;
    logic             c_fire;
    logic             accept;
    logic [IDX_W-1:0] c_idx;
    logic [1:0]       c_lane;
    logic [31:0]      c_old;
    logic [31:0]      c_merged;
    logic [31:0]      c_load;
    logic [31:0]      c_rdata;
    logic [31:0]      c_shifted;
    logic             mem_we;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && req_valid;
    assign c_fire    = (ZERO_WAIT && accept) || ((state == WAIT) && (cnt == 4'd0));

    // Select which copy of the request the commit edge works on
    always_comb begin
        c_we    = lat_we;
        c_size  = lat_size;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        if (state == IDLE) begin
            c_we    = req_we;
            c_size  = req_size;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end
    end

    assign c_idx  = c_addr[IDX_W+1:2];
    assign c_lane = c_addr[1:0];

    // Reject illegal size, misalignment and out-of-range word index
    always_comb begin
        c_err = 1'b0;
        if (c_size == 2'b11)                          c_err = 1'b1;
        if ((c_size == 2'b01) && c_addr[0])           c_err = 1'b1;
        if ((c_size == 2'b10) && (c_lane != 2'b00))   c_err = 1'b1;
        if ({2'b00, c_addr[31:2]} >= DEPTH_L)         c_err = 1'b1;
    end

    assign c_old = mem[c_idx];

    // Lane merge for stores and lane extract for loads
    always_comb begin
        c_merged  = c_wdata;
        c_shifted = c_old >> {c_lane, 3'b000};
        c_load    = c_old;
        case (c_size)
            2'b00: begin
                c_merged = (c_old & ~(32'h0000_00FF << {c_lane, 3'b000}))
                         | ({24'd0, c_wdata[7:0]} << {c_lane, 3'b000});
                c_load   = {24'd0, c_shifted[7:0]};
            end
            2'b01: begin
                c_merged  = (c_old & ~(32'h0000_FFFF << {c_lane[1], 4'b0000}))
                          | ({16'd0, c_wdata[15:0]} << {c_lane[1], 4'b0000});
                c_shifted = c_old >> {c_lane[1], 4'b0000};
                c_load    = {16'd0, c_shifted[15:0]};
            end
            default: begin
                c_merged = c_wdata;
                c_load   = c_old;
            end
        endcase
    end

    assign c_rdata = (c_we || c_err) ? 32'd0 : c_load;
    assign mem_we  = c_fire && c_we && !c_err;

    // Word array: written only on a committing, error-free store; never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[c_idx] <= c_merged;
        end
    end

    // Request FSM: accept, count wait states, commit, hold response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        if (!ZERO_WAIT) begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (c_fire) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= c_err;
                rsp_rdata <= c_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES of
// 1, 3 and 0 share clock and reset. Expected values are hand-computed.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [1:0]  req_size  [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_size(req_size[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2])
    );

    // scoreboard compare points
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // driver: one request, latency counted in edges from the accept edge
    task automatic do_req(input int d, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_size[d]  = size;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        if (rsp_ready[d] === 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic txn(input string tag, input int d, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_q.push_back(exp_rdata);
        do_req(d, we, size, addr, wdata, rd, er, lat);
        chk32({tag, " rdata"}, rd, exp_q.pop_front());
        chk1({tag, " err"}, er, exp_err);
        chk32({tag, " lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_size[i]  = 2'b00;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            rsp_ready[i] = 1'b1;
        end
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // reset state
        for (int i = 0; i < 3; i++) begin
            chk1("rst req_ready", req_ready[i], 1'b1);
            chk1("rst rsp_valid", rsp_valid[i], 1'b0);
            chk1("rst rsp_err", rsp_err[i], 1'b0);
            chk32("rst rsp_rdata", rsp_rdata[i], 32'd0);
            chk1("rst busy", busy[i], 1'b0);
        end

        // WAIT_CYCLES=1: word store / load, latency 2
        txn("st_w 0x10", 0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
        txn("ld_w 0x10", 0, 1'b0, 2'b10, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2);

        // byte merge
        txn("st_w zero", 0, 1'b1, 2'b10, 32'h10, 32'h0, 32'd0, 1'b0, 2);
        txn("st_b 0x11", 0, 1'b1, 2'b00, 32'h11, 32'hFFFFFF5A, 32'd0, 1'b0, 2);
        txn("ld_w merge", 0, 1'b0, 2'b10, 32'h10, 32'd0, 32'h00005A00, 1'b0, 2);
        txn("ld_h 0x12 zero", 0, 1'b0, 2'b01, 32'h12, 32'd0, 32'h0, 1'b0, 2);

        // zero-extended extracts
        txn("st_w 80FF1234", 0, 1'b1, 2'b10, 32'h10, 32'h80FF1234, 32'd0, 1'b0, 2);
        txn("ld_b 0x13", 0, 1'b0, 2'b00, 32'h13, 32'd0, 32'h00000080, 1'b0, 2);
        txn("ld_h 0x12", 0, 1'b0, 2'b01, 32'h12, 32'd0, 32'h000080FF, 1'b0, 2);
        txn("ld_b 0x10", 0, 1'b0, 2'b00, 32'h10, 32'd0, 32'h00000034, 1'b0, 2);
        txn("ld_h 0x10", 0, 1'b0, 2'b01, 32'h10, 32'd0, 32'h00001234, 1'b0, 2);

        // misaligned and illegal size
        txn("st_w misalign", 0, 1'b1, 2'b10, 32'h12, 32'hFFFFFFFF, 32'd0, 1'b1, 2);
        txn("ld_w after mis", 0, 1'b0, 2'b10, 32'h10, 32'd0, 32'h80FF1234, 1'b0, 2);
        txn("st_h odd", 0, 1'b1, 2'b01, 32'h11, 32'hFFFFFFFF, 32'd0, 1'b1, 2);
        txn("ld_h misalign", 0, 1'b0, 2'b01, 32'h13, 32'd0, 32'd0, 1'b1, 2);
        txn("st_h 0x12", 0, 1'b1, 2'b01, 32'h12, 32'hCAFEABCD, 32'd0, 1'b0, 2);
        txn("ld_w half merge", 0, 1'b0, 2'b10, 32'h10, 32'd0, 32'hABCD1234, 1'b0, 2);
        txn("ld size11", 0, 1'b0, 2'b11, 32'h10, 32'd0, 32'd0, 1'b1, 2);
        txn("st size11", 0, 1'b1, 2'b11, 32'h10, 32'h0, 32'd0, 1'b1, 2);

        // range boundary and no aliasing of rejected stores
        txn("st_w 0x0", 0, 1'b1, 2'b10, 32'h0, 32'h11111111, 32'd0, 1'b0, 2);
        txn("st_w oor", 0, 1'b1, 2'b10, 32'h400, 32'h22222222, 32'd0, 1'b1, 2);
        txn("ld_w oor", 0, 1'b0, 2'b10, 32'h400, 32'd0, 32'd0, 1'b1, 2);
        txn("ld_w high oor", 0, 1'b0, 2'b10, 32'h80000000, 32'd0, 32'd0, 1'b1, 2);
        txn("ld_w 0x0", 0, 1'b0, 2'b10, 32'h0, 32'd0, 32'h11111111, 1'b0, 2);
        txn("st_w last", 0, 1'b1, 2'b10, 32'h3FC, 32'h76543210, 32'd0, 1'b0, 2);
        txn("ld_w last", 0, 1'b0, 2'b10, 32'h3FC, 32'd0, 32'h76543210, 1'b0, 2);

        // back-pressure: response held, requests ignored while busy
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_size[0]  = 2'b10;
        req_addr[0]  = 32'h10;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk1("bp rise", rsp_valid[0], 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid[0] = 1'b1;
                req_we[0]    = 1'b1;
                req_size[0]  = 2'b10;
                req_addr[0]  = 32'h10;
                req_wdata[0] = 32'h0BAD0BAD;
            end
            if (i == 3) req_valid[0] = 1'b0;
            @(posedge clk);
            #1;
            chk1("bp hold valid", rsp_valid[0], 1'b1);
            chk32("bp hold rdata", rsp_rdata[0], 32'hABCD1234);
            chk1("bp hold err", rsp_err[0], 1'b0);
            chk1("bp hold req_ready", req_ready[0], 1'b0);
        end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk1("bp release valid", rsp_valid[0], 1'b0);
        chk1("bp release req_ready", req_ready[0], 1'b1);
        chk1("bp release busy", busy[0], 1'b0);
        txn("ld_w after bp", 0, 1'b0, 2'b10, 32'h10, 32'd0, 32'hABCD1234, 1'b0, 2);

        // WAIT_CYCLES=3: reset during WAIT discards the store
        txn("w3 st_w", 1, 1'b1, 2'b10, 32'h20, 32'h12345678, 32'd0, 1'b0, 4);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_size[1]  = 2'b10;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        chk1("w3 busy in wait", busy[1], 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("w3 async busy", busy[1], 1'b0);
        chk1("w3 async req_ready", req_ready[1], 1'b1);
        chk1("w3 async rsp_valid", rsp_valid[1], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        txn("w3 ld_w old", 1, 1'b0, 2'b10, 32'h20, 32'd0, 32'h12345678, 1'b0, 4);

        // WAIT_CYCLES=0: single-cycle latency
        txn("w0 st_w", 2, 1'b1, 2'b10, 32'h3FC, 32'hA5A5C3A5, 32'd0, 1'b0, 1);
        txn("w0 ld_w", 2, 1'b0, 2'b10, 32'h3FC, 32'd0, 32'hA5A5C3A5, 1'b0, 1);
        txn("w0 ld_b", 2, 1'b0, 2'b00, 32'h3FD, 32'd0, 32'h000000C3, 1'b0, 1);
        txn("w0 size11", 2, 1'b0, 2'b11, 32'h0, 32'd0, 32'd0, 1'b1, 1);

        // reset in RESP: committed store survives, response dropped
        @(negedge clk);
        rsp_ready[2] = 1'b0;
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_size[2]  = 2'b10;
        req_addr[2]  = 32'h40;
        req_wdata[2] = 32'h77777777;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        chk1("w0 resp valid", rsp_valid[2], 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("w0 rst drops rsp", rsp_valid[2], 1'b0);
        @(negedge clk);
        rst_n        = 1'b1;
        rsp_ready[2] = 1'b1;
        txn("w0 ld committed", 2, 1'b0, 2'b10, 32'h40, 32'd0, 32'h77777777, 1'b0, 1);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
